// File: rtl/wb_write_queue_if.sv
// Register-file write-port bus: pipeline writeback, mult/div result handshake,
// hazard queries and the registered write port.
interface wb_write_queue_if #(parameter int AW = 2);
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [31:0] md_pc;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        query_busy1;
    logic        query_busy2;
    logic [AW:0] count;
    logic        WriteEnable;
    logic [4:0]  WriteAddress;
    logic [31:0] WriteData;
    logic [31:0] WritePC;

    modport master (
        output pipe_we, pipe_addr, pipe_data, pipe_pc,
        output md_valid, md_addr, md_data, md_pc,
        output query_addr1, query_addr2,
        input  md_ready, query_busy1, query_busy2, count,
        input  WriteEnable, WriteAddress, WriteData, WritePC
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, pipe_pc,
        input  md_valid, md_addr, md_data, md_pc,
        input  query_addr1, query_addr2,
        output md_ready, query_busy1, query_busy2, count,
        output WriteEnable, WriteAddress, WriteData, WritePC
    );
endinterface

// File: rtl/wb_write_queue.sv
// Single register-file write port shared by pipeline writeback (always wins)
// and a small FIFO of mult/div results that drains on free cycles.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             Reset,
    wb_write_queue_if.slave  bus
);
    logic [4:0]  fifoAddr [DEPTH];
    logic [31:0] fifoData [DEPTH];
    logic [31:0] fifoPc   [DEPTH];

    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   fifoCount, countNext;
    logic          writeEnableQ;
    logic [4:0]    writeAddrQ;
    logic [31:0]   writeDataQ, writePcQ;

    logic mdReady, enq, deq, pipeWrite;
    logic busy1, busy2;
    logic [AW-1:0] slotIdx, slotOff;

    assign mdReady   = fifoCount < (AW+1)'(DEPTH);
    // $0 results complete the handshake but are dropped.
    assign enq       = bus.md_valid && mdReady && (bus.md_addr != 5'd0);
    assign pipeWrite = bus.pipe_we && (bus.pipe_addr != 5'd0);
    assign deq       = !pipeWrite && (fifoCount != '0);

    always_comb begin
        countNext = fifoCount;
        case ({enq, deq})
            2'b10:   countNext = fifoCount + 1'b1;
            2'b01:   countNext = fifoCount - 1'b1;
            default: countNext = fifoCount;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            fifoCount    <= '0;
            writeEnableQ <= 1'b0;
            writeAddrQ   <= 5'd0;
            writeDataQ   <= 32'd0;
            writePcQ     <= 32'd0;
        end else begin
            if (enq) wrPtr <= wrPtr + 1'b1;
            if (deq) rdPtr <= rdPtr + 1'b1;
            fifoCount <= countNext;
            if (pipeWrite) begin
                writeEnableQ <= 1'b1;
                writeAddrQ   <= bus.pipe_addr;
                writeDataQ   <= bus.pipe_data;
                writePcQ     <= bus.pipe_pc;
            end else if (deq) begin
                writeEnableQ <= 1'b1;
                writeAddrQ   <= fifoAddr[rdPtr];
                writeDataQ   <= fifoData[rdPtr];
                writePcQ     <= fifoPc[rdPtr];
            end else begin
                writeEnableQ <= 1'b0;
            end
        end
    end

    // Storage is not reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifoAddr[wrPtr] <= bus.md_addr;
            fifoData[wrPtr] <= bus.md_data;
            fifoPc[wrPtr]   <= bus.md_pc;
        end
    end

    always_comb begin
        busy1   = 1'b0;
        busy2   = 1'b0;
        slotIdx = '0;
        slotOff = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotIdx = AW'(i);
            slotOff = slotIdx - rdPtr;
            if ({1'b0, slotOff} < fifoCount) begin
                if (fifoAddr[slotIdx] == bus.query_addr1) busy1 = 1'b1;
                if (fifoAddr[slotIdx] == bus.query_addr2) busy2 = 1'b1;
            end
        end
        // Register file has no bypass, so the word sitting on the port is still pending.
        if (writeEnableQ && writeAddrQ == bus.query_addr1) busy1 = 1'b1;
        if (writeEnableQ && writeAddrQ == bus.query_addr2) busy2 = 1'b1;
        if (bus.query_addr1 == 5'd0) busy1 = 1'b0;
        if (bus.query_addr2 == 5'd0) busy2 = 1'b0;
    end

    assign bus.md_ready     = mdReady;
    assign bus.count        = fifoCount;
    assign bus.query_busy1  = busy1;
    assign bus.query_busy2  = busy2;
    assign bus.WriteEnable  = writeEnableQ;
    assign bus.WriteAddress = writeAddrQ;
    assign bus.WriteData    = writeDataQ;
    assign bus.WritePC      = writePcQ;
endmodule
